// File: rtl/matrix_transpose_stream.sv
// Double-buffered streaming N x N transpose with valid/ready on both sides.
// Two ping-pong banks let one matrix load while the other drains.
module matrix_transpose_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int N          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic                  in_mode,
    input  logic [DATA_WIDTH-1:0] in_row  [0:N-1],
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_row [0:N-1],
    output logic                  out_last
);

    localparam int            PW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [DATA_WIDTH-1:0] r_bank [0:1][0:N-1][0:N-1];
    logic [1:0]            r_full;
    logic [1:0]            r_mode;
    logic                  r_wr_sel;
    logic                  r_rd_sel;
    logic [PW-1:0]         r_wr_row;
    logic [PW-1:0]         r_rd_beat;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_wr_wrap;
    logic                  w_rd_wrap;
    logic [1:0]            w_set;
    logic [1:0]            w_clr;

    // in_rdy is held low during reset even though all flags are already clear
    assign in_rdy     = rst & ~r_full[r_wr_sel];
    assign w_in_fire  = in_val & in_rdy;
    assign out_val    = r_full[r_rd_sel];
    assign w_out_fire = out_val & out_rdy;
    assign w_wr_wrap  = w_in_fire & (r_wr_row == LAST);
    assign w_rd_wrap  = w_out_fire & (r_rd_beat == LAST);
    assign out_last   = out_val & (r_rd_beat == LAST);

    assign w_set = w_wr_wrap ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr = w_rd_wrap ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full    <= '0;
            r_mode    <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_wr_row  <= '0;
            r_rd_beat <= '0;
        end else begin
            // fill and drain always target different banks, so both may land
            r_full <= (r_full | w_set) & ~w_clr;
            if (w_in_fire) begin
                r_wr_row <= w_wr_wrap ? '0 : r_wr_row + 1'b1;
                if (w_wr_wrap) begin
                    r_wr_sel <= ~r_wr_sel;
                end
                if (r_wr_row == '0) begin
                    r_mode[r_wr_sel] <= in_mode;
                end
            end
            if (w_out_fire) begin
                r_rd_beat <= w_rd_wrap ? '0 : r_rd_beat + 1'b1;
                if (w_rd_wrap) begin
                    r_rd_sel <= ~r_rd_sel;
                end
            end
        end
    end

    // Bank contents are meaningless until full, so they carry no reset
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            for (int c = 0; c < N; c++) begin
                r_bank[r_wr_sel][r_wr_row][c] <= in_row[c];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_row[i] = r_mode[r_rd_sel] ? r_bank[r_rd_sel][r_rd_beat][i]
                                          : r_bank[r_rd_sel][i][r_rd_beat];
        end
    end

endmodule
